// File: rtl/shape_programmer.sv
// ---------------------------------------------------------------------------
// shape_programmer
//
// Sits at the head of a daisy chain of shape renderers. Normally it forwards
// the upstream pixel stream with one cycle of registered latency. When a
// shape command is accepted it waits for the upstream stream to enter
// blanking, then replaces the pixel words with one register-write word per
// selected register of the target renderer, back-to-back.
//
// Ports
//   clk, rst              single clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_target            chain position of the renderer to program
//   cmd_mask              register write enables (x, y, width, height, color)
//   cmd_xcoord..cmd_color register values to write
//   pix_x/pix_y/pix_data  upstream pixel stream
//   pix_blank             upstream is in blanking, pixels may be displaced
//   program_out, x_out,   chain head bus: program words or forwarded pixels
//   y_out, data_out
//   cmd_err               pulse: command rejected, target out of range
//   overrun               pulse: a live pixel was dropped while sending
// ---------------------------------------------------------------------------
module shape_programmer #(
  parameter int NUM_SHAPES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_target,
  input  logic [4:0]  cmd_mask,
  input  logic [10:0] cmd_xcoord,
  input  logic [11:0] cmd_ycoord,
  input  logic [10:0] cmd_width,
  input  logic [11:0] cmd_height,
  input  logic [11:0] cmd_color,
  input  logic [10:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic [11:0] pix_data,
  input  logic        pix_blank,
  output logic        program_out,
  output logic [10:0] x_out,
  output logic [11:0] y_out,
  output logic [11:0] data_out,
  output logic        cmd_err,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    SEND       = 2'd2
  } state_t;

  // Target range limit widened by one bit so the comparison cannot wrap.
  localparam logic [11:0] NumShapesW = 12'(NUM_SHAPES);

  state_t      state_q,   state_d;
  logic [10:0] target_q,  target_d;
  logic [4:0]  mask_q,    mask_d;
  logic [10:0] xcoord_q,  xcoord_d;
  logic [11:0] ycoord_q,  ycoord_d;
  logic [10:0] width_q,   width_d;
  logic [11:0] height_q,  height_d;
  logic [11:0] color_q,   color_d;

  logic        program_q, program_d;
  logic [10:0] xOut_q,    xOut_d;
  logic [11:0] yOut_q,    yOut_d;
  logic [11:0] dataOut_q, dataOut_d;
  logic        err_q,     err_d;
  logic        overrun_q, overrun_d;

  logic [2:0]  selId;
  logic [11:0] selValue;
  logic [4:0]  maskLeft;

  assign cmd_ready   = (state_q == IDLE);
  assign program_out = program_q;
  assign x_out       = xOut_q;
  assign y_out       = yOut_q;
  assign data_out    = dataOut_q;
  assign cmd_err     = err_q;
  assign overrun     = overrun_q;

  // Lowest still-pending register ID. The downward loop lets the lowest set
  // bit win. mask_q is never zero while a word is being emitted.
  always_comb begin
    selId = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (mask_q[i]) selId = 3'(i);
    end
  end

  // Value of the selected register, 11-bit fields zero-extended.
  always_comb begin
    selValue = 12'd0;
    case (selId)
      3'd0:    selValue = {1'b0, xcoord_q};
      3'd1:    selValue = ycoord_q;
      3'd2:    selValue = {1'b0, width_q};
      3'd3:    selValue = height_q;
      3'd4:    selValue = color_q;
      default: selValue = 12'd0;
    endcase
  end

  // Pending mask once the current word has gone out.
  assign maskLeft = mask_q & ~(5'b00001 << selId);

  // Next-state and output logic. Every cycle forwards the pixel unless a
  // register word is emitted, in which case the word replaces the pixel.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    mask_d    = mask_q;
    xcoord_d  = xcoord_q;
    ycoord_d  = ycoord_q;
    width_d   = width_q;
    height_d  = height_q;
    color_d   = color_q;
    program_d = 1'b0;
    xOut_d    = pix_x;
    yOut_d    = pix_y;
    dataOut_d = pix_data;
    err_d     = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          mask_d   = cmd_mask;
          xcoord_d = cmd_xcoord;
          ycoord_d = cmd_ycoord;
          width_d  = cmd_width;
          height_d = cmd_height;
          color_d  = cmd_color;
          if ({1'b0, cmd_target} >= NumShapesW) begin
            err_d = 1'b1;
          end else if (cmd_mask != 5'd0) begin
            state_d = WAIT_BLANK;
          end
        end
      end

      WAIT_BLANK: begin
        if (pix_blank) begin
          program_d = 1'b1;
          xOut_d    = target_q;
          yOut_d    = {9'd0, selId};
          dataOut_d = selValue;
          mask_d    = maskLeft;
          state_d   = (maskLeft == 5'd0) ? IDLE : SEND;
        end
      end

      SEND: begin
        // Once started the burst always completes; a live pixel arriving
        // now is lost, which is flagged one cycle later.
        program_d = 1'b1;
        xOut_d    = target_q;
        yOut_d    = {9'd0, selId};
        dataOut_d = selValue;
        mask_d    = maskLeft;
        overrun_d = ~pix_blank;
        state_d   = (maskLeft == 5'd0) ? IDLE : SEND;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched command and registered chain head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= 11'd0;
      mask_q    <= 5'd0;
      xcoord_q  <= 11'd0;
      ycoord_q  <= 12'd0;
      width_q   <= 11'd0;
      height_q  <= 12'd0;
      color_q   <= 12'd0;
      program_q <= 1'b0;
      xOut_q    <= 11'd0;
      yOut_q    <= 12'd0;
      dataOut_q <= 12'd0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      mask_q    <= mask_d;
      xcoord_q  <= xcoord_d;
      ycoord_q  <= ycoord_d;
      width_q   <= width_d;
      height_q  <= height_d;
      color_q   <= color_d;
      program_q <= program_d;
      xOut_q    <= xOut_d;
      yOut_q    <= yOut_d;
      dataOut_q <= dataOut_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_shape_programmer.sv
// ---------------------------------------------------------------------------
// tb_shape_programmer
//
// Directed bench for shape_programmer. Inputs change 1 time unit after a
// rising edge and registered outputs are sampled 1 time unit after the next
// rising edge. A small behavioural renderer chain of four listens on the
// chain head bus so that programming can be checked end to end.
// ---------------------------------------------------------------------------
module tb_shape_programmer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_target;
  logic [4:0]  cmd_mask;
  logic [10:0] cmd_xcoord;
  logic [11:0] cmd_ycoord;
  logic [10:0] cmd_width;
  logic [11:0] cmd_height;
  logic [11:0] cmd_color;
  logic [10:0] pix_x;
  logic [11:0] pix_y;
  logic [11:0] pix_data;
  logic        pix_blank;
  logic        program_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [11:0] data_out;
  logic        cmd_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Renderer chain model: renderer k keeps five registers.
  logic [11:0] rendReg [4][5];

  shape_programmer #(.NUM_SHAPES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_mask    (cmd_mask),
    .cmd_xcoord  (cmd_xcoord),
    .cmd_ycoord  (cmd_ycoord),
    .cmd_width   (cmd_width),
    .cmd_height  (cmd_height),
    .cmd_color   (cmd_color),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .pix_blank   (pix_blank),
    .program_out (program_out),
    .x_out       (x_out),
    .y_out       (y_out),
    .data_out    (data_out),
    .cmd_err     (cmd_err),
    .overrun     (overrun)
  );

  // 10 time unit clock period.
  always #5 clk = ~clk;

  // Renderers latch register words addressed to their own chain position.
  always @(negedge clk) begin
    if (program_out && x_out < 11'd4 && y_out < 12'd5) begin
      rendReg[x_out[1:0]][y_out[2:0]] = data_out;
    end
  end

  // Returns the color renderer k draws at (px, py), or 0 outside its rectangle.
  function automatic logic [11:0] renderAt(int k, int px, int py);
    int rx, ry, rw, rh;
    rx = int'(rendReg[k][0]);
    ry = int'(rendReg[k][1]);
    rw = int'(rendReg[k][2]);
    rh = int'(rendReg[k][3]);
    if (px >= rx && px < rx + rw && py >= ry && py < ry + rh)
      return rendReg[k][4];
    return 12'd0;
  endfunction

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [10:0] px, input logic [11:0] py,
                               input logic [11:0] pd, input logic blank);
    pix_x     = px;
    pix_y     = py;
    pix_data  = pd;
    pix_blank = blank;
  endtask

  task automatic setCommand(input logic valid, input logic [10:0] target,
                            input logic [4:0] mask, input logic [10:0] xc,
                            input logic [11:0] yc, input logic [10:0] w,
                            input logic [11:0] h, input logic [11:0] c);
    cmd_valid  = valid;
    cmd_target = target;
    cmd_mask   = mask;
    cmd_xcoord = xc;
    cmd_ycoord = yc;
    cmd_width  = w;
    cmd_height = h;
    cmd_color  = c;
  endtask

  task automatic checkWord(input string tag, input logic [10:0] tgt,
                           input logic [11:0] id, input logic [11:0] val);
    checkOutput({tag, ".prog"}, 32'(program_out), 32'd1);
    checkOutput({tag, ".x"},    32'(x_out),       32'(tgt));
    checkOutput({tag, ".y"},    32'(y_out),       32'(id));
    checkOutput({tag, ".data"}, 32'(data_out),    32'(val));
  endtask

  logic [11:0] fullVals [5];
  logic [11:0] sumBefore [4];

  initial begin
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 5; r++)
        rendReg[k][r] = 12'd0;

    // Reset holds every output low even with live inputs and clocks.
    rst = 1'b1;
    setCommand(1'b0, 11'd0, 5'd0, 11'd0, 12'd0, 11'd0, 12'd0, 12'd0);
    applyStimulus(11'd5, 12'd7, 12'hABC, 1'b0);
    step();
    step();
    checkOutput("rst.prog",    32'(program_out), 32'd0);
    checkOutput("rst.x",       32'(x_out),       32'd0);
    checkOutput("rst.y",       32'(y_out),       32'd0);
    checkOutput("rst.data",    32'(data_out),    32'd0);
    checkOutput("rst.err",     32'(cmd_err),     32'd0);
    checkOutput("rst.overrun", 32'(overrun),     32'd0);
    checkOutput("rst.ready",   32'(cmd_ready),   32'd1);
    rst = 1'b0;

    // Passthrough with one cycle latency.
    step();
    checkOutput("pass.prog", 32'(program_out), 32'd0);
    checkOutput("pass.x",    32'(x_out),       32'd5);
    checkOutput("pass.y",    32'(y_out),       32'd7);
    checkOutput("pass.data", 32'(data_out),    32'hABC);

    // Full program of target 3 while already in blanking.
    fullVals = '{12'd10, 12'd20, 12'd30, 12'd40, 12'hF00};
    applyStimulus(11'd9, 12'd9, 12'h111, 1'b1);
    setCommand(1'b1, 11'd3, 5'b11111, 11'd10, 12'd20, 11'd30, 12'd40, 12'hF00);
    checkOutput("full.readyBefore", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    checkOutput("full.acceptProg",  32'(program_out), 32'd0);
    checkOutput("full.acceptReady", 32'(cmd_ready),   32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkWord($sformatf("full.w%0d", i), 11'd3, 12'(i), fullVals[i]);
    end
    checkOutput("full.readyAfter", 32'(cmd_ready), 32'd1);
    step();
    checkOutput("full.tailProg", 32'(program_out), 32'd0);
    checkOutput("full.tailData", 32'(data_out),    32'h111);

    // Sparse mask: four live pixels pass before blanking arrives.
    applyStimulus(11'd50, 12'd60, 12'h070, 1'b0);
    setCommand(1'b1, 11'd1, 5'b10010, 11'd99, 12'h123, 11'd77, 12'd88, 12'h456);
    step();
    cmd_valid = 1'b0;
    checkOutput("sparse.acceptX", 32'(x_out), 32'd50);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(11'(100 + i), 12'(200 + i), 12'(12'h300 + i), 1'b0);
      step();
      checkOutput($sformatf("sparse.p%0d.prog", i), 32'(program_out), 32'd0);
      checkOutput($sformatf("sparse.p%0d.x", i),    32'(x_out), 32'(100 + i));
      checkOutput($sformatf("sparse.p%0d.data", i), 32'(data_out), 32'(12'h300 + i));
    end
    applyStimulus(11'd0, 12'd0, 12'd0, 1'b1);
    step();
    checkWord("sparse.w0", 11'd1, 12'd1, 12'h123);
    step();
    checkWord("sparse.w1", 11'd1, 12'd4, 12'h456);
    checkOutput("sparse.readyAfter", 32'(cmd_ready), 32'd1);
    step();
    checkOutput("sparse.tailProg", 32'(program_out), 32'd0);

    // Out of range target is rejected with a single error pulse.
    setCommand(1'b1, 11'd16, 5'b11111, 11'd1, 12'd2, 11'd3, 12'd4, 12'd5);
    step();
    cmd_valid = 1'b0;
    checkOutput("err.pulse", 32'(cmd_err),     32'd1);
    checkOutput("err.prog",  32'(program_out), 32'd0);
    checkOutput("err.ready", 32'(cmd_ready),   32'd1);
    step();
    checkOutput("err.pulseEnd", 32'(cmd_err),     32'd0);
    checkOutput("err.progLate", 32'(program_out), 32'd0);

    // Highest legal target, width register only (11-bit zero-extended).
    setCommand(1'b1, 11'd15, 5'b00100, 11'd1, 12'd2, 11'h7FF, 12'd4, 12'd5);
    step();
    cmd_valid = 1'b0;
    checkOutput("max.err", 32'(cmd_err), 32'd0);
    step();
    checkWord("max.w0", 11'd15, 12'd2, 12'h7FF);
    checkOutput("max.ready", 32'(cmd_ready), 32'd1);

    // Empty mask: accepted silently.
    setCommand(1'b1, 11'd2, 5'b00000, 11'd1, 12'd2, 11'd3, 12'd4, 12'd5);
    step();
    cmd_valid = 1'b0;
    checkOutput("mask0.err",   32'(cmd_err),   32'd0);
    checkOutput("mask0.ready", 32'(cmd_ready), 32'd1);
    step();
    checkOutput("mask0.prog", 32'(program_out), 32'd0);

    // Blanking drops mid-burst: overrun flagged, burst still completes.
    setCommand(1'b1, 11'd0, 5'b11111, 11'd11, 12'd12, 11'd13, 12'd14, 12'd15);
    step();
    cmd_valid = 1'b0;
    step();
    checkWord("ovr.w0", 11'd0, 12'd0, 12'd11);
    checkOutput("ovr.none0", 32'(overrun), 32'd0);
    pix_blank = 1'b0;
    step();
    checkWord("ovr.w1", 11'd0, 12'd1, 12'd12);
    checkOutput("ovr.pulse", 32'(overrun), 32'd1);
    pix_blank = 1'b1;
    step();
    checkWord("ovr.w2", 11'd0, 12'd2, 12'd13);
    checkOutput("ovr.pulseEnd", 32'(overrun), 32'd0);
    step();
    checkWord("ovr.w3", 11'd0, 12'd3, 12'd14);
    step();
    checkWord("ovr.w4", 11'd0, 12'd4, 12'd15);

    // Reset mid-burst abandons the command.
    setCommand(1'b1, 11'd1, 5'b11111, 11'd21, 12'd22, 11'd23, 12'd24, 12'd25);
    step();
    cmd_valid = 1'b0;
    step();
    checkWord("rstSend.w0", 11'd1, 12'd0, 12'd21);
    step();
    checkWord("rstSend.w1", 11'd1, 12'd1, 12'd22);
    rst = 1'b1;
    #2;
    checkOutput("rstSend.prog", 32'(program_out), 32'd0);
    checkOutput("rstSend.x",    32'(x_out),       32'd0);
    checkOutput("rstSend.data", 32'(data_out),    32'd0);
    step();
    rst = 1'b0;
    applyStimulus(11'd4, 12'd4, 12'h444, 1'b1);
    step();
    checkOutput("rstSend.noWord", 32'(program_out), 32'd0);
    checkOutput("rstSend.ready",  32'(cmd_ready),   32'd1);
    setCommand(1'b1, 11'd2, 5'b00001, 11'd33, 12'd0, 11'd0, 12'd0, 12'd0);
    step();
    cmd_valid = 1'b0;
    step();
    checkWord("rstSend.next", 11'd2, 12'd0, 12'd33);

    // Chain: program renderer 2, others stay untouched.
    for (int k = 0; k < 4; k++)
      sumBefore[k] = rendReg[k][0] + rendReg[k][1] + rendReg[k][2] +
                     rendReg[k][3] + rendReg[k][4];
    setCommand(1'b1, 11'd2, 5'b11111, 11'd40, 12'd50, 11'd20, 12'd10, 12'h0F0);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    for (int k = 0; k < 4; k++) begin
      if (k != 2)
        checkOutput($sformatf("chain.r%0dUntouched", k),
                    32'(rendReg[k][0] + rendReg[k][1] + rendReg[k][2] +
                        rendReg[k][3] + rendReg[k][4]),
                    32'(sumBefore[k]));
    end
    checkOutput("chain.r2x",     32'(rendReg[2][0]), 32'd40);
    checkOutput("chain.r2y",     32'(rendReg[2][1]), 32'd50);
    checkOutput("chain.r2w",     32'(rendReg[2][2]), 32'd20);
    checkOutput("chain.r2h",     32'(rendReg[2][3]), 32'd10);
    checkOutput("chain.r2c",     32'(rendReg[2][4]), 32'h0F0);
    checkOutput("chain.inside",  32'(renderAt(2, 45, 55)), 32'h0F0);
    checkOutput("chain.edgeX",   32'(renderAt(2, 60, 55)), 32'd0);
    checkOutput("chain.edgeY",   32'(renderAt(2, 45, 59)), 32'h0F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
